notch_sequencer: RTL and testbench

Sample-rate controller for the notch filter path between the sine generator and the audio codec. It divides `clk` down to a sample strobe and captures one input sample per strobe. It then starts the filter, waits for its done pulse under a watchdog, and selects filtered or bypass data. The selected word is handed to the codec's L/R input registers on the codec `ready` pulse. It replaces the free-running sample counter and the combinational `sw` mux in top.

---
 rtl/notch_pkg.sv | 19 +
 rtl/tick_divider.sv | 35 +++
 rtl/notch_sequencer.sv | 127 ++++++++++++
 tb/tb_notch_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/notch_pkg.sv
// Shared types and defaults for the notch filter sample-rate sequencer.
package notch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int W_DEFAULT       = 24;
  localparam int DIV_DEFAULT     = 50000;
  localparam int TIMEOUT_DEFAULT = 4096;

  // Wide enough for DIV and TIMEOUT up to 65535.
  localparam int CNT_W = 16;
  localparam int OVR_W = 8;

endpackage

// File: rtl/tick_divider.sv
// Divides clk to a one-cycle sample strobe every DIV cycles.
module tick_divider
  import notch_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Strobe is registered from the next count so it lines up with cnt == DIV-1.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/notch_sequencer.sv
// Captures a sample per strobe, runs the notch filter under a watchdog and
// hands the filtered or bypass word to the codec on its ready pulse.
//
// state | meaning
// IDLE  | waiting for a sample strobe
// LOAD  | sample captured, start pulse to filter
// RUN   | waiting for filt_done, watchdog counting
// DONE  | select filtered/bypass word into out register
module notch_sequencer
  import notch_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int DIV     = DIV_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw,
  input  logic [W-1:0]     data_in,
  output logic             filt_start,
  output logic [W-1:0]     filt_data,
  input  logic             filt_done,
  input  logic [W-1:0]     filt_result,
  input  logic             codec_ready,
  output logic [W-1:0]     dac_data,
  output logic             sample_tick,
  output logic             timeout_err,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [W-1:0]     smp_q, smp_d, res_q, res_d, out_q, out_d, dac_q, dac_d;
  logic             sel_q, sel_d, start_q, start_d, tmo_q, tmo_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  tick_divider #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (sample_tick)
  );

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    smp_d   = smp_q;
    res_d   = res_q;
    out_d   = out_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q;
    dac_d   = codec_ready ? out_q : dac_q;

    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          smp_d   = data_in;
          sel_d   = sw;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A done pulse on the expiry cycle still counts as a real answer.
        if (filt_done) begin
          res_d   = filt_result;
          state_d = ST_DONE;
        end else if (wd_q == WD_LAST) begin
          res_d   = smp_q;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        out_d   = sel_q ? res_q : smp_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sample_tick && (state_q != ST_IDLE) && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end

    start_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      smp_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      dac_q   <= '0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      smp_q   <= smp_d;
      res_q   <= res_d;
      out_q   <= out_d;
      dac_q   <= dac_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign filt_start  = start_q;
  assign filt_data   = smp_q;
  assign dac_data    = dac_q;
  assign timeout_err = tmo_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_notch_sequencer.sv
// Randomised bench for notch_sequencer against a timestamp-based sample model.
module tb_notch_sequencer;

  localparam int W    = 24;
  localparam int DIV  = 8;
  localparam int TO   = 4;
  localparam int TO2  = 16;
  localparam int LAT2 = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sw = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         filt_done = 1'b0;
  logic [W-1:0] filt_result = '0;
  logic         codec_ready = 1'b0;
  logic         filt_start;
  logic [W-1:0] filt_data;
  logic [W-1:0] dac_data;
  logic         sample_tick;
  logic         timeout_err;
  logic [7:0]   overrun_cnt;

  logic         filt_done2 = 1'b0;
  logic [W-1:0] filt_result2 = '0;
  logic         filt_start2;
  logic [W-1:0] filt_data2;
  logic [W-1:0] dac_data2;
  logic         sample_tick2;
  logic         timeout_err2;
  logic [7:0]   overrun_cnt2;

  always #5 clk = ~clk;

  notch_sequencer #(.W(W), .DIV(DIV), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .sw(sw), .data_in(data_in),
    .filt_start(filt_start), .filt_data(filt_data),
    .filt_done(filt_done), .filt_result(filt_result),
    .codec_ready(codec_ready), .dac_data(dac_data),
    .sample_tick(sample_tick), .timeout_err(timeout_err),
    .overrun_cnt(overrun_cnt)
  );

  // Second instance with a slow filter (latency 10 > DIV) to exercise overruns.
  notch_sequencer #(.W(W), .DIV(DIV), .TIMEOUT(TO2)) u_dut_ovr (
    .clk(clk), .reset(reset), .sw(sw), .data_in(data_in),
    .filt_start(filt_start2), .filt_data(filt_data2),
    .filt_done(filt_done2), .filt_result(filt_result2),
    .codec_ready(codec_ready), .dac_data(dac_data2),
    .sample_tick(sample_tick2), .timeout_err(timeout_err2),
    .overrun_cnt(overrun_cnt2)
  );

  int checks = 0;
  int errors = 0;

  // Model: p is the current period; events are absolute period numbers.
  int p, base, busy_end, start_at, out_at, to_at, done_at, start2, n2;
  logic [W-1:0] m_smp, m_out, m_dac, out_val, res_drv;
  logic m_to;
  int m_ovr;

  int k_sw, k_lat;
  bit k_fixed, k_ready_all, k_plus1, k_stray, do_reset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h period=%0d", tag, obs, exp, p);
    end
  endtask

  task automatic run_cycle();
    bit tick_p;
    int lat, d, dn;
    logic [W-1:0] rv;
    tick_p = (p >= base) && (((p - base) % DIV) == DIV - 1);

    chk("sample_tick", {31'd0, sample_tick}, {31'd0, tick_p});
    chk("filt_start", {31'd0, filt_start}, {31'd0, (p == start_at)});
    chk("filt_data", {8'd0, filt_data}, {8'd0, m_smp});
    chk("dac_data", {8'd0, dac_data}, {8'd0, m_dac});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_to});
    chk("overrun_cnt", {24'd0, overrun_cnt}, m_ovr);
    chk("overrun_cnt_slow", {24'd0, overrun_cnt2}, ((n2 / 2) > 255) ? 255 : (n2 / 2));
    if (filt_start2 === 1'b1) start2 = p;

    reset = do_reset;
    if (k_sw == 2) begin
      if ($urandom_range(0, 3) == 0) sw = ~sw;
    end else begin
      sw = k_sw[0];
    end
    data_in     = k_fixed ? 24'h000100 : W'($urandom);
    codec_ready = k_ready_all ? 1'b1 : ($urandom_range(0, 2) == 0);
    filt_done   = (p == done_at);
    filt_result = filt_done ? res_drv : W'($urandom);
    if (!filt_done && k_stray && p > busy_end && $urandom_range(0, 3) == 0) filt_done = 1'b1;
    filt_done2   = (p == start2 + LAT2);
    filt_result2 = W'($urandom);

    if (do_reset) begin
      m_smp = '0; m_out = '0; m_dac = '0; m_to = 1'b0; m_ovr = 0;
      busy_end = -1; start_at = -1; out_at = -1; to_at = -1;
      base = p + 1; n2 = 0; start2 = -100;
    end else begin
      if (codec_ready) m_dac = m_out;
      if (p + 1 == out_at) m_out = out_val;
      if (p + 1 == to_at) m_to = 1'b1;
      if (tick_p) begin
        n2++;
        if (p > busy_end) begin
          m_smp    = data_in;
          start_at = p + 1;
          if (k_lat == -1) begin
            lat = $urandom_range(0, 7);
            lat = (lat >= 6) ? 0 : lat + 1;
          end else begin
            lat = k_lat;
          end
          d       = (lat == 0) ? -1 : start_at + lat;
          res_drv = k_plus1 ? data_in + 1 : W'($urandom);
          done_at = d;
          // RUN occupies periods t+2 .. t+1+TIMEOUT.
          if (d >= p + 2 && d <= p + 1 + TO) begin
            dn = d; rv = res_drv;
          end else begin
            dn = p + 1 + TO; rv = data_in; to_at = dn + 1;
          end
          out_val  = sw ? rv : data_in;
          out_at   = dn + 2;
          busy_end = dn + 1;
        end else if (m_ovr < 255) begin
          m_ovr++;
        end
      end
    end

    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    int g, s0;
    p = 0; base = 0; busy_end = -1; start_at = -1; out_at = -1; to_at = -1;
    done_at = -1; start2 = -100; n2 = 0;
    m_smp = '0; m_out = '0; m_dac = '0; m_to = 1'b0; m_ovr = 0;
    out_val = '0; res_drv = '0;
    k_sw = 1; k_lat = 3; k_fixed = 1; k_ready_all = 1; k_plus1 = 1; k_stray = 0;

    repeat (2) @(posedge clk);
    #1;
    do_reset = 1;
    run_cycle();
    do_reset = 0;

    // Filtered path, latency 3.
    run_n(48);
    chk("dac_filtered", {8'd0, dac_data}, 32'h000101);
    chk("no_timeout_a", {31'd0, timeout_err}, 32'd0);

    // Bypass path; filter still started every sample.
    k_sw = 0;
    run_n(48);
    chk("dac_bypass", {8'd0, dac_data}, 32'h000100);

    // Filter never answers.
    k_sw = 1; k_lat = 0;
    run_n(24);
    chk("timeout_set", {31'd0, timeout_err}, 32'd1);
    chk("dac_timeout", {8'd0, dac_data}, 32'h000100);
    k_lat = 3;
    run_n(24);
    chk("recover_dac", {8'd0, dac_data}, 32'h000101);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Done on the expiry cycle wins.
    do_reset = 1;
    run_cycle();
    do_reset = 0;
    k_lat = 4;
    run_n(32);
    chk("tie_no_timeout", {31'd0, timeout_err}, 32'd0);
    chk("tie_dac", {8'd0, dac_data}, 32'h000101);

    // Random data, sw toggling mid-sample, random latency, stray done pulses.
    k_sw = 2; k_lat = -1; k_fixed = 0; k_ready_all = 0; k_plus1 = 0; k_stray = 1;
    run_n(800);

    // Reset one cycle into RUN, late done pulse follows.
    k_lat = 6; k_stray = 0;
    s0 = start_at;
    g = 0;
    while (!(start_at != s0 && p == start_at + 2) && g < 40) begin
      run_cycle();
      g++;
    end
    checks++;
    assert (g < 40) else begin
      errors++;
      $error("FAIL wait_run observed=%0d expected=<40", g);
    end
    do_reset = 1;
    run_cycle();
    do_reset = 0;
    k_lat = -1;
    g = 0;
    while (sample_tick !== 1'b1 && g < 20) begin
      run_cycle();
      g++;
    end
    chk("first_tick_after_reset", g, DIV - 1);

    // Long run: the slow instance drops every second strobe and saturates.
    k_stray = 1;
    run_n(4900);
    chk("overrun_saturated", {24'd0, overrun_cnt2}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
